// File: rtl/riscv_uc_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package riscv_uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IF    = 3'd1,
    S_ID    = 3'd2,
    S_EX    = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_HALT  = 3'd6,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_BR  = 2'd1;
  localparam logic [1:0] ALU_R   = 2'd2;
  localparam logic [1:0] ALU_I   = 2'd3;

  localparam logic [1:0] MUX1_RS2 = 2'd0;
  localparam logic [1:0] MUX1_IMM = 2'd1;

  localparam logic [1:0] MUX2_MEM = 2'd0;
  localparam logic [1:0] MUX2_ALU = 2'd1;
  localparam logic [1:0] MUX2_PC4 = 2'd2;
  localparam logic [1:0] MUX2_IMM = 2'd3;

  localparam logic [1:0] MUX3_PC4   = 2'd0;
  localparam logic [1:0] MUX3_PCIMM = 2'd1;
  localparam logic [1:0] MUX3_ALU   = 2'd2;

  localparam logic [1:0] MUX4_I  = 2'd0;
  localparam logic [1:0] MUX4_S  = 2'd1;
  localparam logic [1:0] MUX4_B  = 2'd2;
  localparam logic [1:0] MUX4_UJ = 2'd3;

  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI: is_exec_op = 1'b1;
      default:                 is_exec_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_uc_wait_timer.sv
// Wait-state watchdog: counts cycles spent waiting on a ready and flags the
// TIMEOUT-th waiting cycle. TIMEOUT=0 never expires.
module riscv_uc_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  // cnt holds the number of waiting cycles already elapsed, so LAST marks the TIMEOUT-th
  assign expired = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/riscv_uc_mc.sv
// Multicycle control unit: sequences IF/ID/EX/MEM/WB with memory ready
// handshakes, wait timeout, sticky halt/fault and a retired-instruction count.
module riscv_uc_mc
  import riscv_uc_pkg::*;
#(
  parameter int unsigned TIMEOUT        = 16,
  parameter int unsigned CNT_W          = 32,
  parameter bit          HALT_ON_SYSTEM = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic             branch,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_load,
  output logic             pc_reset,
  output logic             imem_req,
  output logic             ir_load,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_file_write,
  output logic [1:0]       alu_op,
  output logic [1:0]       select_mux_1,
  output logic [1:0]       select_mux_2,
  output logic [1:0]       select_mux_3,
  output logic [1:0]       select_mux_4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_t     state, next_state;
  logic [6:0] op_q;
  logic       wait_clear, wait_en, expired;

  assign wait_en    = (state == S_IF) || (state == S_MEM);
  assign wait_clear = (next_state != state);

  riscv_uc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (wait_clear),
    .enable  (wait_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      instret <= '0;
    end else begin
      state <= next_state;
      if (state == S_ID) op_q <= opcode;
      if (pc_load)       instret <= instret + CNT_W'(1);
    end
  end

  always_comb begin
    next_state     = state;
    pc_load        = 1'b0;
    pc_reset       = 1'b0;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    reg_file_write = 1'b0;
    alu_op         = ALU_ADD;
    select_mux_1   = MUX1_RS2;
    select_mux_2   = MUX2_MEM;
    select_mux_3   = MUX3_PC4;
    select_mux_4   = MUX4_I;
    halted         = 1'b0;
    fault          = 1'b0;

    case (state)
      S_IDLE: begin
        pc_reset = 1'b1;
        if (start) next_state = S_IF;
      end
      S_IF: begin
        imem_req = 1'b1;
        // a ready on the expiring cycle takes priority over the timeout
        if (imem_ready) begin
          ir_load    = 1'b1;
          next_state = S_ID;
        end else if (expired) begin
          next_state = S_FAULT;
        end
      end
      S_ID: begin
        if (is_exec_op(opcode))                          next_state = S_EX;
        else if (opcode == OP_SYSTEM && HALT_ON_SYSTEM)  next_state = S_HALT;
        else                                             next_state = S_FAULT;
      end
      S_EX: begin
        next_state = S_WB;
        case (op_q)
          OP_R: begin
            select_mux_1 = MUX1_RS2;
            alu_op       = ALU_R;
          end
          OP_I: begin
            select_mux_1 = MUX1_IMM;
            alu_op       = ALU_I;
            select_mux_4 = MUX4_I;
          end
          OP_LOAD: begin
            select_mux_1 = MUX1_IMM;
            select_mux_4 = MUX4_I;
            next_state   = S_MEM;
          end
          OP_STORE: begin
            select_mux_1 = MUX1_IMM;
            select_mux_4 = MUX4_S;
            next_state   = S_MEM;
          end
          OP_BRANCH: begin
            select_mux_1 = MUX1_RS2;
            alu_op       = ALU_BR;
            select_mux_4 = MUX4_B;
            pc_load      = 1'b1;
            select_mux_3 = branch ? MUX3_PCIMM : MUX3_PC4;
            next_state   = S_IF;
          end
          OP_JAL: select_mux_4 = MUX4_UJ;
          OP_JALR: begin
            select_mux_1 = MUX1_IMM;
            select_mux_4 = MUX4_I;
          end
          OP_LUI: select_mux_4 = MUX4_UJ;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_re = (op_q == OP_LOAD);
        mem_we = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            pc_load    = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end else if (expired) begin
          next_state = S_FAULT;
        end
      end
      S_WB: begin
        reg_file_write = 1'b1;
        pc_load        = 1'b1;
        next_state     = S_IF;
        case (op_q)
          OP_LOAD: select_mux_2 = MUX2_MEM;
          OP_JAL: begin
            select_mux_2 = MUX2_PC4;
            select_mux_3 = MUX3_PCIMM;
          end
          OP_JALR: begin
            select_mux_2 = MUX2_PC4;
            select_mux_3 = MUX3_ALU;
          end
          OP_LUI:  select_mux_2 = MUX2_IMM;
          default: select_mux_2 = MUX2_ALU;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_uc_mc.sv
// Self-checking bench for riscv_uc_mc: reactive table vectors, a randomized
// instruction stream against a per-instruction cycle model, and corner sequences.
module tb_riscv_uc_mc;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, SYS = 7'b1110011;

  logic       clk, reset, start, branch, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic       pc_load, pc_reset, imem_req, ir_load, mem_re, mem_we, reg_file_write;
  logic [1:0] alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4;
  logic       halted, fault;
  logic [3:0] instret;

  logic       d2_pc_load, d2_pc_reset, d2_imem_req, d2_ir_load, d2_mem_re, d2_mem_we, d2_rfw;
  logic [1:0] d2_alu_op, d2_m1, d2_m2, d2_m3, d2_m4;
  logic       d2_halted, d2_fault;
  logic [3:0] d2_instret;

  riscv_uc_mc #(.TIMEOUT(4), .CNT_W(4), .HALT_ON_SYSTEM(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch(branch),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_load(pc_load), .pc_reset(pc_reset), .imem_req(imem_req), .ir_load(ir_load),
    .mem_re(mem_re), .mem_we(mem_we), .reg_file_write(reg_file_write),
    .alu_op(alu_op), .select_mux_1(select_mux_1), .select_mux_2(select_mux_2),
    .select_mux_3(select_mux_3), .select_mux_4(select_mux_4),
    .halted(halted), .fault(fault), .instret(instret)
  );

  // second unit: no timeout, SYSTEM treated as illegal
  riscv_uc_mc #(.TIMEOUT(0), .CNT_W(4), .HALT_ON_SYSTEM(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .branch(branch),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_load(d2_pc_load), .pc_reset(d2_pc_reset), .imem_req(d2_imem_req), .ir_load(d2_ir_load),
    .mem_re(d2_mem_re), .mem_we(d2_mem_we), .reg_file_write(d2_rfw),
    .alu_op(d2_alu_op), .select_mux_1(d2_m1), .select_mux_2(d2_m2),
    .select_mux_3(d2_m3), .select_mux_4(d2_m4),
    .halted(d2_halted), .fault(d2_fault), .instret(d2_instret)
  );

  typedef struct packed {
    logic       pc_load, pc_reset, imem_req, ir_load, mem_re, mem_we, rfw;
    logic [1:0] alu, m1, m2, m3, m4;
    logic       halted, fault;
    logic [3:0] instret;
  } ctl_t;

  typedef struct {
    logic [6:0] op;
    logic       br;
    int         ifw;
    int         mw;
    int         cyc;
    logic       rfw;
    logic [1:0] m2;
  } vec_t;

  ctl_t       act;
  int         total, bad;
  logic [3:0] mdl_cnt;

  assign act = {pc_load, pc_reset, imem_req, ir_load, mem_re, mem_we, reg_file_write,
                alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4,
                halted, fault, instret};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_ctl(input string nm, input ctl_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic ctl_t z();
    ctl_t c = '0;
    c.instret = mdl_cnt;
    return c;
  endfunction

  function automatic ctl_t ex_exp(input logic [6:0] op, input logic br);
    ctl_t c = z();
    case (op)
      R:    c.alu = 2'd2;
      I:    begin c.m1 = 2'd1; c.alu = 2'd3; end
      LD:   c.m1 = 2'd1;
      ST:   begin c.m1 = 2'd1; c.m4 = 2'd1; end
      BR:   begin c.alu = 2'd1; c.m4 = 2'd2; c.pc_load = 1'b1; c.m3 = {1'b0, br}; end
      JAL:  c.m4 = 2'd3;
      JALR: c.m1 = 2'd1;
      LUI:  c.m4 = 2'd3;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t wb_exp(input logic [6:0] op);
    ctl_t c = z();
    c.rfw = 1'b1;
    c.pc_load = 1'b1;
    case (op)
      LD:   c.m2 = 2'd0;
      JAL:  begin c.m2 = 2'd2; c.m3 = 2'd1; end
      JALR: begin c.m2 = 2'd2; c.m3 = 2'd2; end
      LUI:  c.m2 = 2'd3;
      default: c.m2 = 2'd1;
    endcase
    return c;
  endfunction

  // one cycle: drive readies at negedge, compare just after, retire into the model
  task automatic cyc(input logic ir, input logic dr, input ctl_t exp, input string nm);
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    check_ctl(nm, exp);
    if (exp.pc_load) mdl_cnt = mdl_cnt + 4'd1;
    @(negedge clk);
  endtask

  task automatic go();
    ctl_t c;
    start = 1'b1;
    c = z();
    c.pc_reset = 1'b1;
    cyc(1'b0, 1'b0, c, "idle");
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    mdl_cnt = '0;
    @(negedge clk);
    go();
  endtask

  // expected cycle-by-cycle controls for one instruction from the IF entry onward
  task automatic run_instr(input logic [6:0] op, input logic br, input int ifw, input int mw);
    ctl_t c;
    opcode = op;
    branch = br;
    for (int k = 0; k <= ifw; k++) begin
      c = z(); c.imem_req = 1'b1; c.ir_load = (k == ifw);
      cyc(k == ifw, 1'b0, c, "if");
    end
    cyc(1'b0, 1'b0, z(), "id");
    cyc(1'b0, 1'b0, ex_exp(op, br), "ex");
    if (op == LD || op == ST) begin
      for (int k = 0; k <= mw; k++) begin
        c = z(); c.mem_re = (op == LD); c.mem_we = (op == ST);
        c.pc_load = (op == ST) && (k == mw);
        cyc(1'b0, k == mw, c, "mem");
      end
    end
    if (op != BR && op != ST) cyc(1'b0, 1'b0, wb_exp(op), "wb");
  endtask

  // reacts to the DUT's requests and measures cycles until the next fetch
  task automatic react(input vec_t v);
    int n = 0, ic = 0, mc = 0;
    logic left = 1'b0, done = 1'b0, seen_rfw = 1'b0;
    logic [1:0] m2 = 2'd0;
    opcode = v.op;
    branch = v.br;
    while (!done && n < 40) begin
      if (imem_req && left) begin
        done = 1'b1;
      end else begin
        imem_ready = imem_req && (ic == v.ifw);
        if (imem_req) ic++; else left = 1'b1;
        dmem_ready = (mem_re || mem_we) && (mc == v.mw);
        if (mem_re || mem_we) mc++;
        #1;
        if (reg_file_write) begin seen_rfw = 1'b1; m2 = select_mux_2; end
        n++;
        @(negedge clk);
      end
    end
    check_int("tab_cycles", n, v.cyc);
    check_int("tab_rfw", int'(seen_rfw), int'(v.rfw));
    check_int("tab_mux2", int'(m2), int'(v.m2));
    mdl_cnt = mdl_cnt + 4'd1;
  endtask

  vec_t       tab [12];
  logic [6:0] ops [8];
  ctl_t       c;

  initial begin
    tab[0]  = '{R,    1'b0, 0, 0, 4, 1'b1, 2'd1};
    tab[1]  = '{I,    1'b0, 0, 0, 4, 1'b1, 2'd1};
    tab[2]  = '{LD,   1'b0, 0, 0, 5, 1'b1, 2'd0};
    tab[3]  = '{LD,   1'b0, 0, 3, 8, 1'b1, 2'd0};
    tab[4]  = '{ST,   1'b0, 0, 0, 4, 1'b0, 2'd0};
    tab[5]  = '{BR,   1'b1, 0, 0, 3, 1'b0, 2'd0};
    tab[6]  = '{BR,   1'b0, 0, 0, 3, 1'b0, 2'd0};
    tab[7]  = '{JAL,  1'b0, 0, 0, 4, 1'b1, 2'd2};
    tab[8]  = '{JALR, 1'b0, 0, 0, 4, 1'b1, 2'd2};
    tab[9]  = '{LUI,  1'b0, 0, 0, 4, 1'b1, 2'd3};
    tab[10] = '{R,    1'b0, 2, 0, 6, 1'b1, 2'd1};
    tab[11] = '{ST,   1'b0, 3, 2, 9, 1'b0, 2'd0};
    ops = '{R, I, LD, ST, BR, JAL, JALR, LUI};

    total = 0; bad = 0; mdl_cnt = '0;
    reset = 1'b0; start = 1'b0; opcode = '0; branch = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    c = '0; c.pc_reset = 1'b1;
    check_ctl("reset_state", c);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    go();

    foreach (tab[i]) react(tab[i]);

    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));

    // ready on the last permitted wait cycle must not fault
    run_instr(R, 1'b0, 3, 0);
    run_instr(LD, 1'b0, 0, 3);
    check_int("boundary_no_fault", int'(fault), 0);

    // asynchronous reset in the middle of a store's MEM wait
    opcode = ST;
    c = z(); c.imem_req = 1'b1; c.ir_load = 1'b1;
    cyc(1'b1, 1'b0, c, "mm_if");
    cyc(1'b0, 1'b0, z(), "mm_id");
    cyc(1'b0, 1'b0, ex_exp(ST, 1'b0), "mm_ex");
    imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    check_int("mm_we", int'(mem_we), 1);
    #1 reset = 1'b0;
    #1;
    c = '0; c.pc_reset = 1'b1;
    check_ctl("mm_reset", c);
    @(negedge clk);
    reset = 1'b1;
    mdl_cnt = '0;
    go();
    c = z(); c.imem_req = 1'b1;
    cyc(1'b0, 1'b0, c, "mm_first_if");

    // fetch timeout: this is the 2nd waiting cycle already
    for (int k = 1; k < 4; k++) begin
      c = z(); c.imem_req = 1'b1;
      cyc(1'b0, 1'b0, c, "to_wait");
    end
    start = 1'b1;
    c = z(); c.fault = 1'b1;
    cyc(1'b1, 1'b1, c, "to_fault");
    cyc(1'b1, 1'b1, c, "to_sticky");
    start = 1'b0;
    check_int("to_d2_nofault", int'(d2_fault), 0);

    // SYSTEM: halt on the main unit, illegal on the second
    do_reset();
    opcode = SYS;
    c = z(); c.imem_req = 1'b1; c.ir_load = 1'b1;
    cyc(1'b1, 1'b0, c, "sys_if");
    cyc(1'b0, 1'b0, z(), "sys_id");
    start = 1'b1;
    c = z(); c.halted = 1'b1;
    cyc(1'b1, 1'b1, c, "sys_halt");
    cyc(1'b1, 1'b1, c, "sys_sticky");
    start = 1'b0;
    check_int("sys_d2_fault", int'(d2_fault), 1);

    do_reset();
    opcode = 7'h7F;
    c = z(); c.imem_req = 1'b1; c.ir_load = 1'b1;
    cyc(1'b1, 1'b0, c, "ill_if");
    cyc(1'b0, 1'b0, z(), "ill_id");
    c = z(); c.fault = 1'b1;
    cyc(1'b0, 1'b0, c, "ill_fault");

    // instret wraps after 2^CNT_W retirements
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(BR, 1'($urandom_range(0, 1)), 0, 0);
    check_int("instret_wrap", int'(instret), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
